axi_wr_master: RTL and testbench

- Single-outstanding AXI3 write master that sits directly upstream of axi_slave and drives its AW, W and B channels.
- Accepts a burst command plus a beat data stream from local logic, issues one AW request, streams W beats with the correct wid and wlast, then collects the B response.
- Returns the response to the command side.
- Used as the RTL stimulus engine and as the write port of future integration tops.

---
 rtl/axi_wr_master_pkg.sv | 11 +
 rtl/axi_wr_master.sv | 159 +++++++++++++++
 tb/tb_axi_wr_master.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_wr_master_pkg.sv
// axi_wr_master_pkg: AXI burst/response codes and write-master FSM states
package axi_wr_master_pkg;
   localparam logic [1:0] BURST_FIXED = 2'd0;
   localparam logic [1:0] BURST_INCR  = 2'd1;
   localparam logic [1:0] BURST_WRAP  = 2'd2;
   localparam logic [1:0] RESP_OKAY   = 2'd0;
   localparam logic [1:0] RESP_EXOKAY = 2'd1;
   localparam logic [1:0] RESP_SLVERR = 2'd2;
   localparam logic [1:0] RESP_DECERR = 2'd3;
   typedef enum logic [1:0] {ST_IDLE, ST_ADDR, ST_DATA, ST_RESP} wr_state_e;
endpackage

// File: rtl/axi_wr_master.sv
// axi_wr_master: single-outstanding AXI3 write master (AW, pass-through W, B to response port)
module axi_wr_master
   import axi_wr_master_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int ID_W   = 4
) (
   input  logic                aclk,
   input  logic                arst,
   input  logic                cmd_valid,
   output logic                cmd_ready,
   input  logic [ID_W-1:0]     cmd_id,
   input  logic [ADDR_W-1:0]   cmd_addr,
   input  logic [3:0]          cmd_len,
   input  logic [2:0]          cmd_size,
   input  logic [1:0]          cmd_burst,
   input  logic                wd_valid,
   output logic                wd_ready,
   input  logic [DATA_W-1:0]   wd_data,
   input  logic [DATA_W/8-1:0] wd_strb,
   output logic                rsp_valid,
   input  logic                rsp_ready,
   output logic [ID_W-1:0]     rsp_id,
   output logic [1:0]          rsp_resp,
   output logic                rsp_idmis,
   output logic [ID_W-1:0]     awid,
   output logic [ADDR_W-1:0]   awaddr,
   output logic [3:0]          awlen,
   output logic [2:0]          awsize,
   output logic [1:0]          awburst,
   output logic [1:0]          awlock,
   output logic [3:0]          awcache,
   output logic [2:0]          awprot,
   output logic [3:0]          awqos,
   output logic [3:0]          awregion,
   output logic                awvalid,
   input  logic                awready,
   output logic [ID_W-1:0]     wid,
   output logic [DATA_W-1:0]   wdata,
   output logic [DATA_W/8-1:0] wstrb,
   output logic                wlast,
   output logic                wvalid,
   input  logic                wready,
   input  logic [ID_W-1:0]     bid,
   input  logic [1:0]          bresp,
   input  logic                bvalid,
   output logic                bready,
   output logic                busy
);
   wr_state_e         state_q, state_d;
   logic [3:0]        beat_cnt_q, beat_cnt_d;
   logic              cmd_ready_q, cmd_ready_d;
   logic              rsp_valid_q, rsp_valid_d;
   logic [ID_W-1:0]   rsp_id_q, rsp_id_d;
   logic [1:0]        rsp_resp_q, rsp_resp_d;
   logic              rsp_idmis_q, rsp_idmis_d;
   logic [ID_W-1:0]   awid_q, awid_d;
   logic [ADDR_W-1:0] awaddr_q, awaddr_d;
   logic [3:0]        awlen_q, awlen_d;
   logic [2:0]        awsize_q, awsize_d;
   logic [1:0]        awburst_q, awburst_d;
   logic              in_data;

   assign in_data   = (state_q == ST_DATA);
   assign wvalid    = in_data & wd_valid;
   assign wd_ready  = in_data & wready;
   assign wlast     = in_data & (beat_cnt_q == awlen_q);
   assign wdata     = wd_data;
   assign wstrb     = wd_strb;
   assign wid       = awid_q;
   assign awvalid   = (state_q == ST_ADDR);
   assign bready    = (state_q == ST_RESP);
   assign busy      = (state_q != ST_IDLE);
   assign cmd_ready = cmd_ready_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_id    = rsp_id_q;
   assign rsp_resp  = rsp_resp_q;
   assign rsp_idmis = rsp_idmis_q;
   assign awid      = awid_q;
   assign awaddr    = awaddr_q;
   assign awlen     = awlen_q;
   assign awsize    = awsize_q;
   assign awburst   = awburst_q;
   assign awlock    = '0;
   assign awcache   = '0;
   assign awprot    = '0;
   assign awqos     = '0;
   assign awregion  = '0;

   always_comb begin
      state_d     = state_q;
      beat_cnt_d  = beat_cnt_q;
      rsp_valid_d = rsp_valid_q & ~rsp_ready;
      rsp_id_d    = rsp_id_q;
      rsp_resp_d  = rsp_resp_q;
      rsp_idmis_d = rsp_idmis_q;
      awid_d      = awid_q;
      awaddr_d    = awaddr_q;
      awlen_d     = awlen_q;
      awsize_d    = awsize_q;
      awburst_d   = awburst_q;
      case (state_q)
         ST_IDLE: if (cmd_valid && cmd_ready_q) begin
            awid_d     = cmd_id;
            awaddr_d   = cmd_addr;
            awlen_d    = cmd_len;
            awsize_d   = cmd_size;
            awburst_d  = cmd_burst;
            beat_cnt_d = '0;
            state_d    = ST_ADDR;
         end
         ST_ADDR: state_d = awready ? ST_DATA : ST_ADDR;
         ST_DATA: if (wvalid && wready) begin
            beat_cnt_d = beat_cnt_q + 4'd1;
            state_d    = wlast ? ST_RESP : ST_DATA;
         end
         ST_RESP: if (bvalid) begin
            rsp_id_d    = bid;
            rsp_resp_d  = bresp;
            rsp_idmis_d = (bid != awid_q);
            rsp_valid_d = 1'b1;
            state_d     = ST_IDLE;
         end
      endcase
      // a retiring response frees cmd_ready only from the following cycle
      cmd_ready_d = (state_d == ST_IDLE) & ~rsp_valid_d;
   end

   always_ff @(posedge aclk or negedge arst) begin
      if (!arst) begin
         state_q     <= ST_IDLE;
         beat_cnt_q  <= '0;
         cmd_ready_q <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_id_q    <= '0;
         rsp_resp_q  <= '0;
         rsp_idmis_q <= 1'b0;
         awid_q      <= '0;
         awaddr_q    <= '0;
         awlen_q     <= '0;
         awsize_q    <= '0;
         awburst_q   <= '0;
      end else begin
         state_q     <= state_d;
         beat_cnt_q  <= beat_cnt_d;
         cmd_ready_q <= cmd_ready_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_id_q    <= rsp_id_d;
         rsp_resp_q  <= rsp_resp_d;
         rsp_idmis_q <= rsp_idmis_d;
         awid_q      <= awid_d;
         awaddr_q    <= awaddr_d;
         awlen_q     <= awlen_d;
         awsize_q    <= awsize_d;
         awburst_q   <= awburst_d;
      end
   end
endmodule

// File: tb/tb_axi_wr_master.sv
// tb_axi_wr_master: directed self-checking bench for axi_wr_master
module tb_axi_wr_master;
   logic        aclk = 1'b0;
   logic        arst;
   logic        cmd_valid, cmd_ready;
   logic [3:0]  cmd_id;
   logic [31:0] cmd_addr;
   logic [3:0]  cmd_len;
   logic [2:0]  cmd_size;
   logic [1:0]  cmd_burst;
   logic        wd_valid, wd_ready;
   logic [31:0] wd_data;
   logic [3:0]  wd_strb;
   logic        rsp_valid, rsp_ready, rsp_idmis;
   logic [3:0]  rsp_id;
   logic [1:0]  rsp_resp;
   logic [3:0]  awid, awlen, awcache, awqos, awregion;
   logic [31:0] awaddr;
   logic [2:0]  awsize, awprot;
   logic [1:0]  awburst, awlock;
   logic        awvalid, awready;
   logic [3:0]  wid;
   logic [31:0] wdata;
   logic [3:0]  wstrb;
   logic        wlast, wvalid, wready;
   logic [3:0]  bid;
   logic [1:0]  bresp;
   logic        bvalid, bready, busy;
   int          checks = 0;
   int          failures = 0;

   axi_wr_master #(.ADDR_W(32), .DATA_W(32), .ID_W(4)) dut (
      .aclk(aclk), .arst(arst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_id(cmd_id), .cmd_addr(cmd_addr),
      .cmd_len(cmd_len), .cmd_size(cmd_size), .cmd_burst(cmd_burst),
      .wd_valid(wd_valid), .wd_ready(wd_ready), .wd_data(wd_data), .wd_strb(wd_strb),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_resp(rsp_resp),
      .rsp_idmis(rsp_idmis),
      .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
      .awlock(awlock), .awcache(awcache), .awprot(awprot), .awqos(awqos), .awregion(awregion),
      .awvalid(awvalid), .awready(awready),
      .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
      .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready), .busy(busy)
   );

   always #5 aclk = ~aclk;

   initial begin
      #100000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   // command sources must only issue legal WRAP bursts
   always @(negedge aclk)
      if (arst && cmd_valid && cmd_burst == 2'd2)
         assert ((cmd_len == 4'd1 || cmd_len == 4'd3 || cmd_len == 4'd7 || cmd_len == 4'd15) &&
                 ((cmd_addr & ((32'd1 << cmd_size) - 32'd1)) == 32'd0))
         else begin
            failures++;
            $error("FAIL wrap_legal len=%0d addr=%0h", cmd_len, cmd_addr);
         end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge aclk);
      #1;
   endtask

   task automatic cmd_issue(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                            input logic [2:0] size, input logic [1:0] burst);
      bit hs = 0;
      cmd_id = id; cmd_addr = addr; cmd_len = len; cmd_size = size; cmd_burst = burst;
      cmd_valid = 1'b1;
      for (int c = 0; c < 20 && !hs; c++) begin
         @(negedge aclk);
         hs = cmd_ready;
         step();
      end
      cmd_valid = 1'b0;
      chk("cmd_accept", hs, 1);
   endtask

   task automatic aw_phase(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                           input int stall);
      bit hs = 0;
      awready = 1'b0;
      wd_valid = 1'b1;
      wready = 1'b1;
      for (int k = 0; k < stall; k++) begin
         chk("aw_stall_valid", awvalid, 1);
         chk("aw_stall_addr", awaddr, addr);
         chk("aw_stall_len", awlen, len);
         chk("aw_stall_id", awid, id);
         chk("aw_stall_no_w", wvalid, 0);
         step();
      end
      awready = 1'b1;
      for (int c = 0; c < 20 && !hs; c++) begin
         @(negedge aclk);
         hs = awvalid;
         chk("aw_no_w", wvalid, 0);
         step();
      end
      awready = 1'b0;
      chk("aw_handshake", hs, 1);
      chk("aw_dropped", awvalid, 0);
   endtask

   task automatic w_phase(input logic [3:0] id, input int len, input int n,
                          input logic [31:0] base, input logic [3:0] strb, input bit gap);
      int i = 0;
      for (int cyc = 0; cyc < 64 && i < n; cyc++) begin
         wd_valid = 1'b1;
         wd_data = base + i;
         wd_strb = strb;
         wready = gap ? (cyc % 2 == 0) : 1'b1;
         @(negedge aclk);
         if (wvalid && wready) begin
            chk("w_data", wdata, base + i);
            chk("w_strb", wstrb, strb);
            chk("w_id", wid, id);
            chk("w_last", wlast, i == len);
            i++;
         end
         step();
      end
      chk("w_beats", i, n);
      if (n == len + 1) begin
         chk("w_done_wvalid", wvalid, 0);
         wd_valid = 1'b0;
      end
   endtask

   task automatic b_phase(input logic [3:0] b_id, input logic [1:0] b_resp,
                          input logic [3:0] e_id, input logic [1:0] e_resp, input logic e_mis);
      bit hs = 0;
      bvalid = 1'b1; bid = b_id; bresp = b_resp;
      for (int c = 0; c < 20 && !hs; c++) begin
         @(negedge aclk);
         hs = bready;
         step();
      end
      bvalid = 1'b0;
      chk("b_handshake", hs, 1);
      chk("rsp_valid", rsp_valid, 1);
      chk("rsp_id", rsp_id, e_id);
      chk("rsp_resp", rsp_resp, e_resp);
      chk("rsp_idmis", rsp_idmis, e_mis);
      chk("rsp_busy", busy, 0);
      chk("rsp_bready", bready, 0);
   endtask

   task automatic retire();
      rsp_ready = 1'b1;
      step();
      rsp_ready = 1'b0;
      chk("retire_rsp_valid", rsp_valid, 0);
      chk("retire_cmd_ready", cmd_ready, 1);
   endtask

   initial begin
      arst = 1'b0;
      cmd_valid = 0; cmd_id = 0; cmd_addr = 0; cmd_len = 0; cmd_size = 0; cmd_burst = 0;
      wd_valid = 0; wd_data = 0; wd_strb = 0; rsp_ready = 0;
      awready = 0; wready = 0; bid = 0; bresp = 0; bvalid = 0;
      #1;
      chk("rst_awvalid", awvalid, 0);
      chk("rst_wvalid", wvalid, 0);
      chk("rst_bready", bready, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_cmd_ready", cmd_ready, 0);
      chk("rst_busy", busy, 0);
      chk("rst_awaddr", awaddr, 0);
      chk("rst_awcache", {awlock, awcache, awprot, awqos, awregion}, 0);
      repeat (2) step();
      arst = 1'b1;
      step();
      chk("idle_cmd_ready", cmd_ready, 1);

      // single beat; a stray bvalid before RESP must be ignored
      bvalid = 1'b1; bid = 4'd3;
      cmd_issue(4'd3, 32'h100, 4'd0, 3'd2, 2'd1);
      chk("s_addr_busy", busy, 1);
      chk("s_addr_cmd_ready", cmd_ready, 0);
      chk("s_addr_bready", bready, 0);
      chk("s_awsize", awsize, 2);
      chk("s_awburst", awburst, 1);
      aw_phase(4'd3, 32'h100, 4'd0, 0);
      bvalid = 1'b0;
      chk("s_no_rsp", rsp_valid, 0);
      w_phase(4'd3, 0, 1, 32'hDEADBEEF, 4'hF, 1'b0);
      b_phase(4'd3, 2'd0, 4'd3, 2'd0, 1'b0);
      retire();

      // 4-beat INCR, wready every other cycle
      cmd_issue(4'd4, 32'h1000, 4'd3, 3'd2, 2'd1);
      aw_phase(4'd4, 32'h1000, 4'd3, 0);
      w_phase(4'd4, 3, 4, 32'hA0000000, 4'h5, 1'b1);
      b_phase(4'd4, 2'd0, 4'd4, 2'd0, 1'b0);
      retire();

      // awready stalled 5 cycles
      cmd_issue(4'd6, 32'h300, 4'd2, 3'd2, 2'd1);
      aw_phase(4'd6, 32'h300, 4'd2, 5);
      w_phase(4'd6, 2, 3, 32'h33330000, 4'hC, 1'b0);
      b_phase(4'd6, 2'd1, 4'd6, 2'd1, 1'b0);
      retire();

      // SLVERR with mismatching bid, then response held while a command waits
      cmd_issue(4'd2, 32'h200, 4'd1, 3'd2, 2'd1);
      aw_phase(4'd2, 32'h200, 4'd1, 0);
      w_phase(4'd2, 1, 2, 32'h22220000, 4'hF, 1'b0);
      b_phase(4'd5, 2'd2, 4'd5, 2'd2, 1'b1);
      cmd_id = 4'd1; cmd_addr = 32'h400; cmd_len = 4'd0; cmd_size = 3'd2; cmd_burst = 2'd1;
      cmd_valid = 1'b1;
      for (int k = 0; k < 4; k++) begin
         step();
         chk("hold_cmd_ready", cmd_ready, 0);
         chk("hold_rsp_valid", rsp_valid, 1);
         chk("hold_rsp_resp", rsp_resp, 2);
         chk("hold_awvalid", awvalid, 0);
      end
      rsp_ready = 1'b1;
      step();
      rsp_ready = 1'b0;
      chk("hold_retired", rsp_valid, 0);
      chk("hold_cmd_ready_next", cmd_ready, 1);
      chk("hold_not_accepted", awvalid, 0);
      step();
      cmd_valid = 1'b0;
      chk("hold_accepted", awvalid, 1);
      chk("hold_awid", awid, 1);
      aw_phase(4'd1, 32'h400, 4'd0, 0);
      w_phase(4'd1, 0, 1, 32'h44440000, 4'h1, 1'b0);
      b_phase(4'd1, 2'd0, 4'd1, 2'd0, 1'b0);
      retire();

      // reset in DATA after 2 of 8 beats
      cmd_issue(4'd8, 32'h2000, 4'd7, 3'd2, 2'd1);
      aw_phase(4'd8, 32'h2000, 4'd7, 0);
      w_phase(4'd8, 7, 2, 32'h80000000, 4'hF, 1'b0);
      wd_valid = 1'b1; wready = 1'b1;
      #1;
      chk("pre_rst_wvalid", wvalid, 1);
      chk("pre_rst_busy", busy, 1);
      arst = 1'b0;
      #1;
      chk("arst_wvalid", wvalid, 0);
      chk("arst_wd_ready", wd_ready, 0);
      chk("arst_awvalid", awvalid, 0);
      chk("arst_bready", bready, 0);
      chk("arst_busy", busy, 0);
      chk("arst_cmd_ready", cmd_ready, 0);
      chk("arst_awaddr", awaddr, 0);
      for (int k = 0; k < 3; k++) begin
         step();
         chk("arst_no_rsp", rsp_valid, 0);
      end
      arst = 1'b1;
      wd_valid = 1'b0; wready = 1'b0;
      step();
      chk("post_rst_cmd_ready", cmd_ready, 1);
      chk("post_rst_no_rsp", rsp_valid, 0);

      // normal WRAP transaction after reset
      cmd_issue(4'd7, 32'h108, 4'd3, 3'd2, 2'd2);
      chk("wrap_awburst", awburst, 2);
      aw_phase(4'd7, 32'h108, 4'd3, 0);
      w_phase(4'd7, 3, 4, 32'h77770000, 4'hF, 1'b0);
      b_phase(4'd7, 2'd0, 4'd7, 2'd0, 1'b0);
      retire();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
